// File: rtl/pce_pad_pkg.sv
// Shared definitions for the PC Engine joypad / multitap responder.
// Button bit positions within a pad byte and the fixed K nibble codes.
package pce_pad_pkg;

   typedef enum logic [2:0] {
      BTN_I      = 3'd0,
      BTN_II     = 3'd1,
      BTN_SELECT = 3'd2,
      BTN_RUN    = 3'd3,
      BTN_UP     = 3'd4,
      BTN_RIGHT  = 3'd5,
      BTN_DOWN   = 3'd6,
      BTN_LEFT   = 3'd7
   } btn_bit_e;

   localparam logic [3:0] PAD_K_CLR  = 4'h0;
   localparam logic [3:0] PAD_K_NONE = 4'hF;

   // Active-low nibble for one pad: directions when sel=1, action buttons when sel=0.
   function automatic logic [3:0] pad_nibble(input logic [7:0] btn, input logic sel);
      logic [3:0] nib;
      if (sel) nib = {btn[BTN_LEFT], btn[BTN_DOWN], btn[BTN_RIGHT], btn[BTN_UP]};
      else     nib = {btn[BTN_RUN], btn[BTN_SELECT], btn[BTN_II], btn[BTN_I]};
      return ~nib;
   endfunction

endpackage

// File: rtl/pad_sync.sv
// Generic multi-bit level synchronizer: STAGES flops per bit, async active-low reset to 0.
module pad_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset_N,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = d;
      for (int s = 1; s < STAGES; s++) sync_d[s] = sync_q[s-1];
   end

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) sync_q <= '0;
      else          sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pad_multitap_responder.sv
// Controller side of the HuC6280 joypad port: SEL/CLR from the CPU select a pad and
// nibble, K returns the active-low button state, with an optional 5-port tap scan.
module pad_multitap_responder
   import pce_pad_pkg::*;
#(
   parameter int NUM_PADS    = 5,
   parameter int MULTITAP_EN = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset_N,
   input  logic                  SEL,
   input  logic                  CLR,
   input  logic [8*NUM_PADS-1:0] BUTTONS,
   output logic [3:0]            K,
   output logic [2:0]            PAD_IDX
);

   localparam logic [2:0] IDX_END = 3'(NUM_PADS);

   logic                  sel_q, sel_d;
   logic [2:0]            idx_q, idx_d;
   logic [3:0]            k_q, k_d;
   logic [8*NUM_PADS-1:0] btn_s;
   logic [7:0]            pad_btn;
   logic                  rise;

   pad_sync #(.WIDTH(8*NUM_PADS), .STAGES(SYNC_STAGES)) u_btn_sync (
      .clock   (clock),
      .reset_N (reset_N),
      .d       (BUTTONS),
      .q       (btn_s)
   );

   always_comb begin
      sel_d = SEL;
      rise  = SEL & ~sel_q;

      // CLR wins over any SEL edge; the count parks at IDX_END (past last pad).
      idx_d = idx_q;
      if (CLR)
         idx_d = '0;
      else if (rise && (MULTITAP_EN != 0) && (idx_q < IDX_END))
         idx_d = idx_q + 3'd1;

      // Nibble is taken from the pad the index lands on this cycle.
      pad_btn = '0;
      for (int p = 0; p < NUM_PADS; p++)
         if (idx_d == 3'(p)) pad_btn = btn_s[8*p +: 8];

      if (CLR)                  k_d = PAD_K_CLR;
      else if (idx_d == IDX_END) k_d = PAD_K_NONE;
      else                      k_d = pad_nibble(pad_btn, SEL);
   end

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         sel_q <= 1'b0;
         idx_q <= '0;
         k_q   <= PAD_K_CLR;
      end else begin
         sel_q <= sel_d;
         idx_q <= idx_d;
         k_q   <= k_d;
      end
   end

   assign K       = k_q;
   assign PAD_IDX = idx_q;

endmodule
